// File: rtl/prism_cfg_arb_if.sv
// Bus bundle for prism_cfg_arb: host and autoload write ports, loader port and status.
// The slave modport is the arbiter's view; the master modport is the surrounding system.
interface prism_cfg_arb_if;
  logic        h_req;
  logic [5:0]  h_addr;
  logic [31:0] h_wdata;
  logic        h_ack;
  logic        h_err;

  logic        a_req;
  logic [5:0]  a_addr;
  logic [31:0] a_wdata;
  logic        a_ack;
  logic        a_err;

  logic        ld_write_req;
  logic [5:0]  ld_addr;
  logic [31:0] ld_wdata;
  logic        ld_busy;

  logic [7:0]  wr_count;
  logic        arb_busy;

  modport slave (
    input  h_req, h_addr, h_wdata, a_req, a_addr, a_wdata, ld_busy,
    output h_ack, h_err, a_ack, a_err, ld_write_req, ld_addr, ld_wdata,
           wr_count, arb_busy
  );

  modport master (
    output h_req, h_addr, h_wdata, a_req, a_addr, a_wdata, ld_busy,
    input  h_ack, h_err, a_ack, a_err, ld_write_req, ld_addr, ld_wdata,
           wr_count, arb_busy
  );
endinterface

// File: rtl/prism_cfg_arb.sv
// Round-robin write arbiter between the host debug bus and the autoload port, feeding the SIT latch loader.
// Optional register-lock feature is built in when PRISM_CFG_ARB_LOCK_EN is defined.
module prism_cfg_arb #(
  parameter int TMO_CYCLES = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  prism_cfg_arb_if.slave bus
);
  localparam int TW = (TMO_CYCLES > 1) ? $clog2(TMO_CYCLES + 1) : 1;
  localparam logic [TW-1:0] TMO_LOAD = TW'(TMO_CYCLES);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t        state;
  state_t        state_next;
  logic          last_a;
  logic          grant_a;
  logic          pick_a;
  logic          first_wait;
  logic          done_enter;
  logic          done_err;
  logic          done_sel_a;
  logic [TW-1:0] tmo;

`ifdef PRISM_CFG_ARB_LOCK_EN
  localparam logic [5:0] LOCK_ADDR = 6'h3F;
  logic locked;
  logic lock_wr;
`endif

  // last_a records who was granted last; on contention the other side wins.
  always_comb begin
    state_next = state;
    pick_a     = 1'b0;
    done_err   = 1'b0;
`ifdef PRISM_CFG_ARB_LOCK_EN
    lock_wr    = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (bus.h_req || bus.a_req) begin
          pick_a     = bus.a_req && (!bus.h_req || !last_a);
          state_next = ISSUE;
`ifdef PRISM_CFG_ARB_LOCK_EN
          if (!pick_a && bus.h_addr == LOCK_ADDR) begin
            lock_wr    = 1'b1;
            state_next = DONE;
          end else if (pick_a && locked) begin
            done_err   = 1'b1;
            state_next = DONE;
          end
`endif
        end
      end
      ISSUE: state_next = WAIT;
      WAIT: begin
        if (!first_wait && !bus.ld_busy) begin
          state_next = DONE;
        end else if (tmo == TW'(1)) begin
          state_next = DONE;
          done_err   = 1'b1;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    done_enter = (state_next == DONE);
    done_sel_a = (state == IDLE) ? pick_a : grant_a;
  end

  // Every output is a flop computed from the upcoming state, so the ack lands in the DONE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      last_a           <= 1'b1;
      grant_a          <= 1'b0;
      first_wait       <= 1'b0;
      tmo              <= '0;
      bus.ld_write_req <= 1'b0;
      bus.ld_addr      <= '0;
      bus.ld_wdata     <= '0;
      bus.h_ack        <= 1'b0;
      bus.h_err        <= 1'b0;
      bus.a_ack        <= 1'b0;
      bus.a_err        <= 1'b0;
      bus.wr_count     <= '0;
      bus.arb_busy     <= 1'b0;
`ifdef PRISM_CFG_ARB_LOCK_EN
      locked           <= 1'b0;
`endif
    end else begin
      state            <= state_next;
      bus.arb_busy     <= (state_next != IDLE);
      bus.ld_write_req <= (state_next == ISSUE);
      bus.h_ack        <= done_enter && !done_sel_a;
      bus.h_err        <= done_enter && !done_sel_a && done_err;
      bus.a_ack        <= done_enter && done_sel_a;
      bus.a_err        <= done_enter && done_sel_a && done_err;
      first_wait       <= (state == ISSUE);

      if (done_enter && !done_err && bus.wr_count != 8'hFF)
        bus.wr_count <= bus.wr_count + 8'd1;

      if (state == IDLE && (bus.h_req || bus.a_req)) begin
        grant_a      <= pick_a;
        last_a       <= pick_a;
        bus.ld_addr  <= pick_a ? bus.a_addr : bus.h_addr;
        bus.ld_wdata <= pick_a ? bus.a_wdata : bus.h_wdata;
      end

      if (state == ISSUE)
        tmo <= TMO_LOAD;
      else if (state == WAIT)
        tmo <= tmo - TW'(1);

`ifdef PRISM_CFG_ARB_LOCK_EN
      if (lock_wr)
        locked <= bus.h_wdata[0];
`endif
    end
  end
endmodule

// File: doc/prism_cfg_arb.md
PRISM_CFG_ARB -- requirements
Module: prism_cfg_arb

Interface
REQ-001 Parameter TMO_CYCLES, default 255, maximum cycles to wait for the loader to finish before aborting with an error.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 h_req, h_addr[5:0], h_wdata[31:0]  input  1/6/32  host debug-bus write request, address and data.
REQ-005 h_ack, h_err  output  1/1  host completion pulse and error flag, valid with the pulse.
REQ-006 a_req, a_addr[5:0], a_wdata[31:0]  input  1/6/32  autoload-port write request, address and data.
REQ-007 a_ack, a_err  output  1/1  autoload completion pulse and error flag.
REQ-008 ld_write_req  output  1  single-cycle write strobe to the SIT latch loader.
REQ-009 ld_addr[5:0], ld_wdata[31:0]  output  6/32  address and data presented to the loader.
REQ-010 ld_busy  input  1  loader busy while shifting data into the latch chain.
REQ-011 wr_count[7:0]  output  8  number of successfully completed writes, saturating.
REQ-012 arb_busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-013 FSM states: IDLE, ISSUE, WAIT, DONE; all outputs are registered.
REQ-014 IDLE: with any req high, select a requester, latch its addr and data into ld_addr and ld_wdata, and go to ISSUE.
REQ-015 Arbitration is round-robin: when both requests are high, grant the requester not granted last; when only one is high, grant it.
REQ-016 ISSUE: ld_write_req is high for exactly this one cycle; load the timeout counter with TMO_CYCLES; go to WAIT.
REQ-017 WAIT: ld_busy is not sampled in the first WAIT cycle; afterwards, ld_busy==0 goes to DONE with status ok.
REQ-018 WAIT: the timeout counter decrements every cycle; on reaching 0 while ld_busy is still high, go to DONE with status error.
REQ-019 DONE: the granted requester's ack is high for one cycle, with err equal to the status; wr_count increments on ok only, saturating at 255; go to IDLE.
REQ-020 ld_addr and ld_wdata stay stable from ISSUE through DONE.
REQ-021 A requester holds req, addr and data until its ack and deasserts req in the cycle after the ack; the arbiter samples req only in IDLE.
REQ-022 Best-case latency: req high in IDLE at cycle N gives ld_write_req at N+1 and ack at N+4 when ld_busy is low at N+3.
REQ-023 A non-granted request stays pending without loss and is served in the IDLE cycle after the current DONE.
REQ-024 h_ack and a_ack are never high in the same cycle.

Reset
REQ-025 Asynchronous assertion of rst_n=0 forces IDLE and clears ld_write_req, ld_addr, ld_wdata, h_ack, h_err, a_ack, a_err, wr_count and arb_busy to 0.
REQ-026 Reset sets the last-granted flag to autoload, so the host wins the first contention.
REQ-027 Reset mid-operation abandons the transfer with no ack issued; the loader's own reset handles the latch state.

Configuration
REQ-028 The macro PRISM_CFG_ARB_LOCK_EN controls a lock feature.
REQ-029 With PRISM_CFG_ARB_LOCK_EN defined, a lock bit exists, cleared by reset.
REQ-030 The lock bit is set by a completed host write to address 6'h3F with wdata[0]=1 and cleared by the same write with wdata[0]=0.
REQ-031 A host write to 6'h3F never reaches the loader and acks after IDLE->DONE with err=0.
REQ-032 While locked, a granted autoload request skips ISSUE and WAIT and acks with a_err=1, with no ld_write_req and no wr_count change.
REQ-033 Without PRISM_CFG_ARB_LOCK_EN, the lock bit does not exist and address 6'h3F is forwarded to the loader like any other address.

Verification
REQ-034 Host only: h_req, h_addr=6'h10, h_wdata=32'hA5A5_0001, with ld_busy high for 3 cycles -> one ld_write_req, then h_ack with h_err=0 and wr_count=1.
REQ-035 Simultaneous h_req and a_req after reset -> host served first, then autoload; ld_write_req pulses twice and wr_count=2.
REQ-036 Back-to-back contention over 4 transfers -> grants alternate H, A, H, A.
REQ-037 ld_busy stuck high with TMO_CYCLES=4 -> a_ack with a_err=1 after the timeout and wr_count unchanged.
REQ-038 rst_n pulsed low during WAIT -> all outputs 0 immediately, no ack, and the next request is served normally.
REQ-039 LOCK_EN build: host writes 6'h3F with data 1, then autoload writes 6'h14 -> a_err=1 and no ld_write_req; after unlock the same write succeeds.
